// File: rtl/csr_trap_ctrl_if.sv
// Signal bundle between the execute stage, csr_trap_ctrl and the single-port CSR RAM.
interface csr_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            csr_req;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_rs1_zero;
  logic            csr_ack;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  logic            trap_req;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_tval;
  logic            mret_req;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  logic            ram_we;
  logic [11:0]     ram_addr;
  logic [XLEN-1:0] ram_wdata;
  logic [XLEN-1:0] ram_rdata;

  modport slave (
    input  csr_req, csr_op, csr_addr, csr_wdata, csr_rs1_zero,
    input  trap_req, trap_cause, trap_pc, trap_tval, mret_req,
    input  ram_rdata,
    output csr_ack, csr_rdata, csr_illegal,
    output redirect_valid, redirect_pc, busy,
    output ram_we, ram_addr, ram_wdata
  );

  modport master (
    output csr_req, csr_op, csr_addr, csr_wdata, csr_rs1_zero,
    output trap_req, trap_cause, trap_pc, trap_tval, mret_req,
    output ram_rdata,
    input  csr_ack, csr_rdata, csr_illegal,
    input  redirect_valid, redirect_pc, busy,
    input  ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Sequences CSR read-modify-write ops, trap entry and MRET over one shared CSR RAM port.
// XLEN must be 32 or 64.
module csr_trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic           clock,
  input  logic           reset,
  csr_trap_ctrl_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  typedef enum logic [3:0] {
    IDLE,
    C_RD,
    C_WR,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_STRD,
    T_STWR,
    T_VRD,
    T_REDIR,
    M_STRD,
    M_STWR,
    M_EPCRD,
    M_REDIR
  } state_t;

  state_t state, state_nxt;
  logic   load_csr, load_trap;

  logic [1:0]      csr_op_p0;
  logic [11:0]     csr_addr_p0;
  logic [XLEN-1:0] csr_wdata_p0;
  logic            csr_rs1_zero_p0;
  logic [XLEN-1:0] trap_cause_p0;
  logic [XLEN-1:0] trap_pc_p0;
  logic [XLEN-1:0] trap_tval_p0;

  logic csr_write_req;
  logic csr_read_only;

  function automatic logic [XLEN-1:0] csr_new_value(input logic [1:0] op,
                                                    input logic [XLEN-1:0] old,
                                                    input logic [XLEN-1:0] operand);
    case (op)
      2'b10:   return old | operand;
      2'b11:   return old & ~operand;
      default: return operand;
    endcase
  endfunction

  // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] cur);
    logic [XLEN-1:0] nxt;
    nxt        = cur;
    nxt[7]     = cur[3];
    nxt[3]     = 1'b0;
    nxt[12:11] = 2'b11;
    return nxt;
  endfunction

  // mstatus on MRET: MIE <- MPIE, MPIE <- 1, MPP stays M on this M-only hart.
  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] cur);
    logic [XLEN-1:0] nxt;
    nxt        = cur;
    nxt[3]     = cur[7];
    nxt[7]     = 1'b1;
    nxt[12:11] = 2'b11;
    return nxt;
  endfunction

  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                  input logic [XLEN-1:0] cause);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    // Vectored mode only applies to interrupts; the add wraps at XLEN bits.
    if (mtvec[1:0] == 2'b01 && cause[XLEN-1])
      return base + {cause[XLEN-3:0], 2'b00};
    return base;
  endfunction

  assign csr_write_req = !csr_op_p0[1] || !csr_rs1_zero_p0;
  assign csr_read_only = (csr_addr_p0[11:10] == 2'b11);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand capture at accept; data registers need no reset.
  always_ff @(posedge clock) begin
    if (load_csr) begin
      csr_op_p0       <= bus.csr_op;
      csr_addr_p0     <= bus.csr_addr;
      csr_wdata_p0    <= bus.csr_wdata;
      csr_rs1_zero_p0 <= bus.csr_rs1_zero;
    end
    if (load_trap) begin
      trap_cause_p0 <= bus.trap_cause;
      trap_pc_p0    <= bus.trap_pc;
      trap_tval_p0  <= bus.trap_tval;
    end
  end

  always_comb begin
    state_nxt          = state;
    load_csr           = 1'b0;
    load_trap          = 1'b0;
    bus.csr_ack        = 1'b0;
    bus.csr_rdata      = '0;
    bus.csr_illegal    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.ram_we         = 1'b0;
    bus.ram_addr       = 12'h000;
    bus.ram_wdata      = '0;

    case (state)
      IDLE: begin
        if (bus.trap_req) begin
          load_trap = 1'b1;
          state_nxt = T_EPC;
        end else if (bus.mret_req) begin
          state_nxt = M_STRD;
        end else if (bus.csr_req) begin
          load_csr  = 1'b1;
          state_nxt = C_RD;
        end
      end

      C_RD: begin
        bus.ram_addr = csr_addr_p0;
        state_nxt    = C_WR;
      end

      C_WR: begin
        bus.ram_addr    = csr_addr_p0;
        bus.csr_ack     = 1'b1;
        bus.csr_rdata   = bus.ram_rdata;
        bus.csr_illegal = csr_write_req && csr_read_only;
        if (csr_write_req && !csr_read_only) begin
          bus.ram_we    = 1'b1;
          bus.ram_wdata = csr_new_value(csr_op_p0, bus.ram_rdata, csr_wdata_p0);
        end
        state_nxt = IDLE;
      end

      T_EPC: begin
        bus.ram_we    = 1'b1;
        bus.ram_addr  = ADDR_MEPC;
        bus.ram_wdata = {trap_pc_p0[XLEN-1:2], 2'b00};
        state_nxt     = T_CAUSE;
      end

      T_CAUSE: begin
        bus.ram_we    = 1'b1;
        bus.ram_addr  = ADDR_MCAUSE;
        bus.ram_wdata = trap_cause_p0;
        state_nxt     = T_TVAL;
      end

      T_TVAL: begin
        bus.ram_we    = 1'b1;
        bus.ram_addr  = ADDR_MTVAL;
        bus.ram_wdata = trap_tval_p0;
        state_nxt     = T_STRD;
      end

      T_STRD: begin
        bus.ram_addr = ADDR_MSTATUS;
        state_nxt    = T_STWR;
      end

      T_STWR: begin
        bus.ram_we    = 1'b1;
        bus.ram_addr  = ADDR_MSTATUS;
        bus.ram_wdata = mstatus_on_trap(bus.ram_rdata);
        state_nxt     = T_VRD;
      end

      T_VRD: begin
        bus.ram_addr = ADDR_MTVEC;
        state_nxt    = T_REDIR;
      end

      T_REDIR: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = trap_target(bus.ram_rdata, trap_cause_p0);
        state_nxt          = IDLE;
      end

      M_STRD: begin
        bus.ram_addr = ADDR_MSTATUS;
        state_nxt    = M_STWR;
      end

      M_STWR: begin
        bus.ram_we    = 1'b1;
        bus.ram_addr  = ADDR_MSTATUS;
        bus.ram_wdata = mstatus_on_mret(bus.ram_rdata);
        state_nxt     = M_EPCRD;
      end

      M_EPCRD: begin
        bus.ram_addr = ADDR_MEPC;
        state_nxt    = M_REDIR;
      end

      M_REDIR: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = {bus.ram_rdata[XLEN-1:2], 2'b00};
        state_nxt          = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed vector table, corner sequences and random ops vs. a CSR-file model.
module tb_csr_trap_ctrl;
  localparam int XLEN = 32;
  localparam int K_CSR = 0, K_TRAP = 1, K_MRET = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  csr_trap_ctrl_if #(.XLEN(XLEN)) bus ();
  csr_trap_ctrl #(.XLEN(XLEN)) dut (.clock(clock), .reset(reset), .bus(bus));

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  int checks = 0, errors = 0;
  int wr_cnt = 0, redir_cnt = 0, wd_viol = 0;

  // RAM model: synchronous write, registered read one cycle after the address.
  always @(posedge clock) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] = bus.ram_wdata;
      wr_cnt++;
    end else begin
      bus.ram_rdata <= mem[bus.ram_addr];
      if (bus.ram_wdata != 32'h0) wd_viol++;
    end
    if (bus.redirect_valid) redir_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Reference: architectural effect of one operation on the CSR file.
  task automatic model_op(input int kind, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input logic rz,
                          input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                          output logic [31:0] e_rd, output logic e_ill, output logic [31:0] e_pc,
                          output int e_lat, output int e_wr);
    logic [31:0] old, s, mtvec, epc;
    logic wr;
    e_rd = 32'h0; e_ill = 1'b0; e_pc = 32'h0;
    if (kind == K_CSR) begin
      old   = ref_mem[addr];
      wr    = (op == 2'b10 || op == 2'b11) ? !rz : 1'b1;
      e_rd  = old;
      e_ill = wr && (addr >= 12'hC00);
      e_lat = 2;
      e_wr  = (wr && !e_ill) ? 1 : 0;
      if (e_wr == 1) begin
        if (op == 2'b10)      ref_mem[addr] = old | wd;
        else if (op == 2'b11) ref_mem[addr] = old & ~wd;
        else                  ref_mem[addr] = wd;
      end
    end else if (kind == K_TRAP) begin
      ref_mem[12'h341] = pc - (pc % 4);
      ref_mem[12'h342] = cause;
      ref_mem[12'h343] = tval;
      s = ref_mem[12'h300];
      ref_mem[12'h300] = (s & ~32'h1888) | (((s >> 3) & 32'h1) << 7) | 32'h1800;
      mtvec = ref_mem[12'h305];
      e_pc  = mtvec - (mtvec % 4);
      if ((mtvec % 4) == 1 && cause >= 32'h8000_0000) e_pc = e_pc + 4 * (cause % 32'h8000_0000);
      e_lat = 7;
      e_wr  = 4;
    end else begin
      s = ref_mem[12'h300];
      ref_mem[12'h300] = (s & ~32'h1888) | (((s >> 7) & 32'h1) << 3) | 32'h0080 | 32'h1800;
      epc   = ref_mem[12'h341];
      e_pc  = epc - (epc % 4);
      e_lat = 4;
      e_wr  = 1;
    end
  endtask

  // Drives one request until its ack/redirect, scrambling operands after accept.
  task automatic run_op(input int kind, input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wd, input logic rz,
                        input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                        output logic [31:0] rd, output logic ill, output logic [31:0] rpc,
                        output int lat, output int writes);
    int w0;
    w0 = wr_cnt;
    bus.csr_op = op; bus.csr_addr = addr; bus.csr_wdata = wd; bus.csr_rs1_zero = rz;
    bus.trap_cause = cause; bus.trap_pc = pc; bus.trap_tval = tval;
    bus.csr_req  = (kind == K_CSR);
    bus.trap_req = (kind == K_TRAP);
    bus.mret_req = (kind == K_MRET);
    lat = -1; rd = 32'h0; ill = 1'b0; rpc = 32'h0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock); @(negedge clock);
      if (c == 1) begin
        bus.csr_op = 2'($urandom); bus.csr_addr = 12'($urandom); bus.csr_wdata = $urandom;
        bus.csr_rs1_zero = 1'($urandom); bus.trap_cause = $urandom;
        bus.trap_pc = $urandom; bus.trap_tval = $urandom;
      end
      if ((kind == K_CSR && bus.csr_ack) || (kind != K_CSR && bus.redirect_valid)) begin
        lat = c; rd = bus.csr_rdata; ill = bus.csr_illegal; rpc = bus.redirect_pc;
        break;
      end
    end
    bus.csr_req = 1'b0; bus.trap_req = 1'b0; bus.mret_req = 1'b0;
    @(posedge clock); @(negedge clock);
    writes = wr_cnt - w0;
  endtask

  typedef struct {
    int          kind;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        rz;
    logic [31:0] cause, pc, tval;
    logic [31:0] exp_rd;
    logic        exp_ill;
    logic [31:0] exp_pc;
    int          exp_lat;
    int          exp_wr;
    logic [11:0] chk_addr;
    logic [31:0] chk_val;
  } vec_t;

  vec_t vt[12];
  logic [11:0] addr_pool[9];

  initial begin
    logic [31:0] rd, rpc, m_rd, m_pc, a_rd;
    logic ill, m_ill;
    int lat, wrs, m_lat, m_wr, redir_at, ack_at, r0;

    reset = 1'b1;
    bus.csr_req = 1'b0; bus.trap_req = 1'b0; bus.mret_req = 1'b0;
    bus.csr_op = 2'b00; bus.csr_addr = 12'h0; bus.csr_wdata = 32'h0; bus.csr_rs1_zero = 1'b0;
    bus.trap_cause = 32'h0; bus.trap_pc = 32'h0; bus.trap_tval = 32'h0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[12'h340] = 32'h1234_5678; mem[12'h300] = 32'h0000_1888; mem[12'hF14] = 32'h0000_ABCD;
    mem[12'hC00] = 32'h0000_0055; mem[12'h305] = 32'h8000_0101;
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ack", bus.csr_ack, 0);
    check("rst_illegal", bus.csr_illegal, 0);
    check("rst_redirect", bus.redirect_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_we", bus.ram_we, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_data", {bus.ram_wdata, bus.csr_rdata} | bus.redirect_pc, 0);
    reset = 1'b0;

    vt[0]  = '{K_CSR, 2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 32'h0, 32'h12345678, 1'b0, 32'h0, 2, 1, 12'h340, 32'hDEADBEEF};
    vt[1]  = '{K_CSR, 2'b10, 12'h300, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h0, 32'h0, 32'h00001888, 1'b0, 32'h0, 2, 0, 12'h300, 32'h00001888};
    vt[2]  = '{K_CSR, 2'b11, 12'h300, 32'h00000008, 1'b0, 32'h0, 32'h0, 32'h0, 32'h00001888, 1'b0, 32'h0, 2, 1, 12'h300, 32'h00001880};
    vt[3]  = '{K_CSR, 2'b01, 12'hF14, 32'h00000001, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0000ABCD, 1'b1, 32'h0, 2, 0, 12'hF14, 32'h0000ABCD};
    vt[4]  = '{K_CSR, 2'b10, 12'hC00, 32'h00000000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h00000055, 1'b0, 32'h0, 2, 0, 12'hC00, 32'h00000055};
    vt[5]  = '{K_CSR, 2'b01, 12'h300, 32'h00000008, 1'b0, 32'h0, 32'h0, 32'h0, 32'h00001880, 1'b0, 32'h0, 2, 1, 12'h300, 32'h00000008};
    vt[6]  = '{K_TRAP, 2'b00, 12'h000, 32'h0, 1'b0, 32'h00000002, 32'h80000102, 32'h13, 32'h0, 1'b0, 32'h80000100, 7, 4, 12'h300, 32'h00001880};
    vt[7]  = '{K_CSR, 2'b01, 12'h300, 32'h00000008, 1'b0, 32'h0, 32'h0, 32'h0, 32'h00001880, 1'b0, 32'h0, 2, 1, 12'h300, 32'h00000008};
    vt[8]  = '{K_TRAP, 2'b00, 12'h000, 32'h0, 1'b0, 32'h80000007, 32'h80000200, 32'h0, 32'h0, 1'b0, 32'h8000011C, 7, 4, 12'h341, 32'h80000200};
    vt[9]  = '{K_MRET, 2'b00, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h80000200, 4, 1, 12'h300, 32'h00001888};
    vt[10] = '{K_CSR, 2'b00, 12'h340, 32'h00000001, 1'b1, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1, 12'h340, 32'h00000001};
    vt[11] = '{K_CSR, 2'b11, 12'h305, 32'h00000003, 1'b0, 32'h0, 32'h0, 32'h0, 32'h80000101, 1'b0, 32'h0, 2, 1, 12'h305, 32'h80000100};

    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].kind, vt[i].op, vt[i].addr, vt[i].wd, vt[i].rz, vt[i].cause, vt[i].pc, vt[i].tval,
             rd, ill, rpc, lat, wrs);
      model_op(vt[i].kind, vt[i].op, vt[i].addr, vt[i].wd, vt[i].rz, vt[i].cause, vt[i].pc, vt[i].tval,
               m_rd, m_ill, m_pc, m_lat, m_wr);
      check($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      check($sformatf("vec%0d_writes", i), wrs, vt[i].exp_wr);
      if (vt[i].kind == K_CSR) begin
        check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
        check($sformatf("vec%0d_illegal", i), ill, vt[i].exp_ill);
      end else begin
        check($sformatf("vec%0d_redirect_pc", i), rpc, vt[i].exp_pc);
      end
      check($sformatf("vec%0d_ram", i), mem[vt[i].chk_addr], vt[i].chk_val);
      check($sformatf("vec%0d_model_diffs", i), mem_diffs(), 0);
    end

    // Trap and CSR requested together: trap first, CSR op right after.
    bus.csr_op = 2'b10; bus.csr_addr = 12'h340; bus.csr_wdata = 32'h0000_00F0; bus.csr_rs1_zero = 1'b0;
    bus.trap_cause = 32'h8000_0003; bus.trap_pc = 32'h0000_4000; bus.trap_tval = 32'h0;
    bus.trap_req = 1'b1; bus.csr_req = 1'b1;
    redir_at = -1; ack_at = -1; a_rd = 32'h0; rpc = 32'h0;
    for (int c = 1; c <= 30 && ack_at < 0; c++) begin
      @(posedge clock); @(negedge clock);
      if (bus.redirect_valid) begin redir_at = c; rpc = bus.redirect_pc; bus.trap_req = 1'b0; end
      if (bus.csr_ack) begin ack_at = c; a_rd = bus.csr_rdata; bus.csr_req = 1'b0; end
    end
    bus.trap_req = 1'b0; bus.csr_req = 1'b0;
    @(posedge clock); @(negedge clock);
    model_op(K_TRAP, 2'b00, 12'h0, 32'h0, 1'b0, 32'h8000_0003, 32'h0000_4000, 32'h0,
             m_rd, m_ill, m_pc, m_lat, m_wr);
    check("prio_redirect_cycle", redir_at, 7);
    check("prio_redirect_pc", rpc, m_pc);
    model_op(K_CSR, 2'b10, 12'h340, 32'h0000_00F0, 1'b0, 32'h0, 32'h0, 32'h0,
             m_rd, m_ill, m_pc, m_lat, m_wr);
    check("prio_ack_cycle", ack_at, 10);
    check("prio_ack_rdata", a_rd, m_rd);
    check("prio_model_diffs", mem_diffs(), 0);

    // Reset during T_STRD: first three trap writes stay, nothing else happens.
    mem[12'h300] = 32'h8; ref_mem[12'h300] = 32'h8;
    bus.trap_cause = 32'h5; bus.trap_pc = 32'h0000_0100; bus.trap_tval = 32'h77;
    bus.trap_req = 1'b1;
    repeat (4) begin @(posedge clock); @(negedge clock); end
    check("abort_busy_before", bus.busy, 1);
    r0 = redir_cnt;
    reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_no_redirect", bus.redirect_valid, 0);
    check("abort_no_we", bus.ram_we, 0);
    bus.trap_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("abort_redirect_count", redir_cnt, r0);
    check("abort_mcause", mem[12'h342], 32'h5);
    ref_mem[12'h341] = 32'h0000_0100; ref_mem[12'h342] = 32'h5; ref_mem[12'h343] = 32'h77;
    check("abort_model_diffs", mem_diffs(), 0);

    addr_pool = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hF14, 12'hC00, 12'h7C0};
    for (int n = 0; n < 200; n++) begin
      int kind, pick;
      logic [1:0] op;
      logic [11:0] addr;
      logic [31:0] wd, cause, pc, tval;
      logic rz;
      pick = $urandom_range(0, 9);
      kind = (pick < 6) ? K_CSR : (pick < 8) ? K_TRAP : K_MRET;
      op   = 2'($urandom);
      addr = ($urandom_range(0, 4) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 8)];
      wd   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rz   = ($urandom_range(0, 2) == 0);
      cause = $urandom_range(0, 1) ? (32'h8000_0000 | 32'($urandom_range(0, 15))) : $urandom;
      pc   = $urandom;
      tval = $urandom;
      run_op(kind, op, addr, wd, rz, cause, pc, tval, rd, ill, rpc, lat, wrs);
      model_op(kind, op, addr, wd, rz, cause, pc, tval, m_rd, m_ill, m_pc, m_lat, m_wr);
      check($sformatf("rnd%0d_latency", n), lat, m_lat);
      check($sformatf("rnd%0d_writes", n), wrs, m_wr);
      if (kind == K_CSR) begin
        check($sformatf("rnd%0d_rdata", n), rd, m_rd);
        check($sformatf("rnd%0d_illegal", n), ill, m_ill);
      end else begin
        check($sformatf("rnd%0d_redirect_pc", n), rpc, m_pc);
      end
      check($sformatf("rnd%0d_model_diffs", n), mem_diffs(), 0);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    check("idle_wdata_zero", wd_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
